// File: rtl/ace_snoop_bcast.sv
// Snoop fan-out/fan-in stage for the ACE CCU: broadcasts one snoop on the AC channel of every targeted port,
// collects the CR responses and returns one merged response plus the first data-supplying port.
module ace_snoop_bcast #(
    parameter int unsigned NoSnpPorts   = 4,
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned AcSnoopWidth = 4,
    parameter int unsigned CrRespWidth  = 5,
    localparam int unsigned IdxW        = $clog2(NoSnpPorts)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NoSnpPorts-1:0]             port_en_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [AddrWidth-1:0]              req_addr_i,
    input  logic [AcSnoopWidth-1:0]           req_snoop_i,
    input  logic [2:0]                        req_prot_i,
    input  logic [IdxW-1:0]                   req_init_i,
    output logic [NoSnpPorts-1:0]             ac_valid_o,
    input  logic [NoSnpPorts-1:0]             ac_ready_i,
    output logic [AddrWidth-1:0]              ac_addr_o,
    output logic [AcSnoopWidth-1:0]           ac_snoop_o,
    output logic [2:0]                        ac_prot_o,
    input  logic [NoSnpPorts-1:0]             cr_valid_i,
    output logic [NoSnpPorts-1:0]             cr_ready_o,
    input  logic [NoSnpPorts*CrRespWidth-1:0] cr_resp_i,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic [CrRespWidth-1:0]            resp_o,
    output logic                              resp_data_vld_o,
    output logic [IdxW-1:0]                   resp_data_idx_o
);

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Bcast = 2'd1,
        Resp  = 2'd2
    } state_e;

    state_e                  state;
    logic                    reqReady;
    logic                    respValid;
    logic [NoSnpPorts-1:0]   acPend;
    logic [NoSnpPorts-1:0]   crPend;
    logic [AddrWidth-1:0]    acAddr;
    logic [AcSnoopWidth-1:0] acSnoop;
    logic [2:0]              acProt;
    logic [CrRespWidth-1:0]  respMerge;
    logic                    dataVld;
    logic [IdxW-1:0]         dataIdx;

    logic [NoSnpPorts-1:0]   tgt;
    logic [NoSnpPorts-1:0]   crReady;
    logic [NoSnpPorts-1:0]   acHs;
    logic [NoSnpPorts-1:0]   crHs;
    logic [CrRespWidth-1:0]  mergeOr;
    logic                    newDtVld;
    logic [IdxW-1:0]         newDtIdx;

    // Target mask: enabled ports minus the initiator (an out-of-range initiator excludes nobody).
    always_comb begin
        tgt = {NoSnpPorts{1'b0}};
        for (int i = 0; i < NoSnpPorts; i++) begin
            if (req_init_i == IdxW'(i)) begin
                tgt[i] = 1'b0;
            end else begin
                tgt[i] = port_en_i[i];
            end
        end
    end

    // A port's CR is only accepted once its AC has been handshaken in an earlier cycle.
    always_comb begin
        crReady = crPend & ~acPend;
        acHs    = acPend & ac_ready_i;
        crHs    = cr_valid_i & crReady;
    end

    // Merge this cycle's CR handshakes; scanning downward leaves the lowest DataTransfer index.
    always_comb begin
        mergeOr  = {CrRespWidth{1'b0}};
        newDtVld = 1'b0;
        newDtIdx = {IdxW{1'b0}};
        for (int i = NoSnpPorts - 1; i >= 0; i--) begin
            if (crHs[i]) begin
                mergeOr = mergeOr | cr_resp_i[i*CrRespWidth +: CrRespWidth];
                if (cr_resp_i[i*CrRespWidth]) begin
                    newDtVld = 1'b1;
                    newDtIdx = IdxW'(i);
                end else begin
                    newDtVld = newDtVld;
                end
            end else begin
                mergeOr = mergeOr;
            end
        end
    end

    // Transaction FSM with all outputs and payload held in registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= Idle;
            reqReady  <= 1'b1;
            respValid <= 1'b0;
            acPend    <= {NoSnpPorts{1'b0}};
            crPend    <= {NoSnpPorts{1'b0}};
            acAddr    <= {AddrWidth{1'b0}};
            acSnoop   <= {AcSnoopWidth{1'b0}};
            acProt    <= 3'b000;
            respMerge <= {CrRespWidth{1'b0}};
            dataVld   <= 1'b0;
            dataIdx   <= {IdxW{1'b0}};
        end else begin
            case (state)
                Idle: begin
                    if (req_valid_i) begin
                        acAddr    <= req_addr_i;
                        acSnoop   <= req_snoop_i;
                        acProt    <= req_prot_i;
                        acPend    <= tgt;
                        crPend    <= tgt;
                        respMerge <= {CrRespWidth{1'b0}};
                        dataVld   <= 1'b0;
                        dataIdx   <= {IdxW{1'b0}};
                        reqReady  <= 1'b0;
                        if (tgt != {NoSnpPorts{1'b0}}) begin
                            state <= Bcast;
                        end else begin
                            state     <= Resp;
                            respValid <= 1'b1;
                        end
                    end else begin
                        reqReady <= 1'b1;
                    end
                end
                Bcast: begin
                    acPend    <= acPend & ~acHs;
                    crPend    <= crPend & ~crHs;
                    respMerge <= respMerge | mergeOr;
                    if (newDtVld && (!dataVld || (newDtIdx < dataIdx))) begin
                        dataVld <= 1'b1;
                        dataIdx <= newDtIdx;
                    end else begin
                        dataVld <= dataVld;
                    end
                    if ((acPend == {NoSnpPorts{1'b0}}) && (crPend == {NoSnpPorts{1'b0}})) begin
                        state     <= Resp;
                        respValid <= 1'b1;
                    end else begin
                        state <= Bcast;
                    end
                end
                Resp: begin
                    if (resp_ready_i) begin
                        state     <= Idle;
                        respValid <= 1'b0;
                        reqReady  <= 1'b1;
                    end else begin
                        state <= Resp;
                    end
                end
                default: begin
                    state     <= Idle;
                    reqReady  <= 1'b1;
                    respValid <= 1'b0;
                    acPend    <= {NoSnpPorts{1'b0}};
                    crPend    <= {NoSnpPorts{1'b0}};
                end
            endcase
        end
    end

    assign req_ready_o     = reqReady;
    assign ac_valid_o      = acPend;
    assign ac_addr_o       = acAddr;
    assign ac_snoop_o      = acSnoop;
    assign ac_prot_o       = acProt;
    assign cr_ready_o      = crReady;
    assign resp_valid_o    = respValid;
    assign resp_o          = respMerge;
    assign resp_data_vld_o = dataVld;
    assign resp_data_idx_o = dataIdx;

endmodule

// File: tb/tb_ace_snoop_bcast.sv
// Directed self-checking bench for ace_snoop_bcast with hand-computed expected values.
module tb_ace_snoop_bcast;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  portEn;
    logic        reqValid;
    logic        reqReady;
    logic [63:0] reqAddr;
    logic [3:0]  reqSnoop;
    logic [2:0]  reqProt;
    logic [1:0]  reqInit;
    logic [3:0]  acValid;
    logic [3:0]  acReady;
    logic [63:0] acAddr;
    logic [3:0]  acSnoop;
    logic [2:0]  acProt;
    logic [3:0]  crValid;
    logic [3:0]  crReady;
    logic [19:0] crResp;
    logic        respValid;
    logic        respReady;
    logic [4:0]  resp;
    logic        respDataVld;
    logic [1:0]  respDataIdx;

    int nChecks = 0;
    int nFails  = 0;

    ace_snoop_bcast dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .port_en_i       (portEn),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .req_addr_i      (reqAddr),
        .req_snoop_i     (reqSnoop),
        .req_prot_i      (reqProt),
        .req_init_i      (reqInit),
        .ac_valid_o      (acValid),
        .ac_ready_i      (acReady),
        .ac_addr_o       (acAddr),
        .ac_snoop_o      (acSnoop),
        .ac_prot_o       (acProt),
        .cr_valid_i      (crValid),
        .cr_ready_o      (crReady),
        .cr_resp_i       (crResp),
        .resp_valid_o    (respValid),
        .resp_ready_i    (respReady),
        .resp_o          (resp),
        .resp_data_vld_o (respDataVld),
        .resp_data_idx_o (respDataIdx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN      = 1'b0;
        portEn    = 4'h0;
        reqValid  = 1'b0;
        reqAddr   = 64'h0;
        reqSnoop  = 4'h0;
        reqProt   = 3'b000;
        reqInit   = 2'd0;
        acReady   = 4'h0;
        crValid   = 4'h0;
        crResp    = 20'h0;
        respReady = 1'b1;
        tick();
        tick();
        check("rst_ac_valid", 64'(acValid), 64'h0);
        check("rst_resp_valid", 64'(respValid), 64'h0);
        check("rst_resp", 64'(resp), 64'h0);
        check("rst_ac_addr", acAddr, 64'h0);
        rstN = 1'b1;
        tick();
        check("idle_req_ready", 64'(reqReady), 64'h1);
        check("idle_cr_ready", 64'(crReady), 64'h0);

        // All ports enabled, initiator 0, everything ready, null responses.
        portEn   = 4'hF;
        reqInit  = 2'd0;
        acReady  = 4'hF;
        crValid  = 4'hF;
        crResp   = 20'h0;
        reqAddr  = 64'h1234_5678_9ABC_DEF0;
        reqSnoop = 4'h7;
        reqProt  = 3'b101;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        check("t1_ac_valid", 64'(acValid), 64'hE);
        check("t1_req_ready", 64'(reqReady), 64'h0);
        check("t1_ac_addr", acAddr, 64'h1234_5678_9ABC_DEF0);
        check("t1_ac_snoop", 64'(acSnoop), 64'h7);
        check("t1_ac_prot", 64'(acProt), 64'h5);
        check("t1_resp_valid_c1", 64'(respValid), 64'h0);
        tick();
        check("t1_ac_valid_c2", 64'(acValid), 64'h0);
        check("t1_cr_ready_c2", 64'(crReady), 64'hE);
        check("t1_resp_valid_c2", 64'(respValid), 64'h0);
        tick();
        check("t1_cr_ready_c3", 64'(crReady), 64'h0);
        check("t1_resp_valid_c3", 64'(respValid), 64'h0);
        tick();
        check("t1_resp_valid", 64'(respValid), 64'h1);
        check("t1_resp", 64'(resp), 64'h0);
        check("t1_data_vld", 64'(respDataVld), 64'h0);
        check("t1_data_idx", 64'(respDataIdx), 64'h0);
        tick();
        check("t1_done_valid", 64'(respValid), 64'h0);
        check("t1_done_ready", 64'(reqReady), 64'h1);

        // Only the initiator enabled: no AC, response next cycle.
        portEn   = 4'b0001;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        check("t2_ac_valid", 64'(acValid), 64'h0);
        check("t2_resp_valid", 64'(respValid), 64'h1);
        check("t2_resp", 64'(resp), 64'h0);
        tick();
        check("t2_req_ready", 64'(reqReady), 64'h1);

        // Initiator 1; ports 2,3 supply data, port 0 PassDirty, port 1 response must be ignored.
        portEn   = 4'hF;
        reqInit  = 2'd1;
        crResp   = {5'b01001, 5'b01001, 5'b11111, 5'b00100};
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        portEn   = 4'h0;
        reqInit  = 2'd2;
        check("t3_ac_valid", 64'(acValid), 64'hD);
        tick();
        tick();
        tick();
        check("t3_resp_valid", 64'(respValid), 64'h1);
        check("t3_resp", 64'(resp), 64'h0D);
        check("t3_data_vld", 64'(respDataVld), 64'h1);
        check("t3_data_idx", 64'(respDataIdx), 64'h2);
        tick();

        // Port 3 AC ready late while CR valid is held early.
        portEn    = 4'hF;
        reqInit   = 2'd0;
        acReady   = 4'b0111;
        crResp    = {5'b00001, 5'b01000, 5'b00000, 5'b11111};
        reqAddr   = 64'hCAFE_F00D_0000_1000;
        respReady = 1'b0;
        reqValid  = 1'b1;
        tick();
        reqValid = 1'b0;
        check("t4_ac_valid_c1", 64'(acValid), 64'hE);
        tick();
        check("t4_ac_valid_c2", 64'(acValid), 64'h8);
        check("t4_cr_ready_c2", 64'(crReady), 64'h6);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_ac_valid_hold", 64'(acValid), 64'h8);
            check("t4_cr_ready_hold", 64'(crReady), 64'h0);
            check("t4_resp_valid_hold", 64'(respValid), 64'h0);
            check("t4_ac_addr_hold", acAddr, 64'hCAFE_F00D_0000_1000);
        end
        acReady = 4'hF;
        tick();
        check("t4_ac_valid_done", 64'(acValid), 64'h0);
        check("t4_cr_ready_p3", 64'(crReady), 64'h8);
        check("t4_resp_valid_c7", 64'(respValid), 64'h0);
        tick();
        check("t4_resp_valid_c8", 64'(respValid), 64'h0);
        tick();
        check("t4_resp_valid", 64'(respValid), 64'h1);
        check("t4_resp", 64'(resp), 64'h09);
        check("t4_data_vld", 64'(respDataVld), 64'h1);
        check("t4_data_idx", 64'(respDataIdx), 64'h3);

        // Response back-pressure with a new request already waiting.
        portEn   = 4'b0110;
        reqInit  = 2'd3;
        reqAddr  = 64'h0000_0000_0000_ABC0;
        reqValid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t5_resp_valid_stall", 64'(respValid), 64'h1);
            check("t5_resp_stall", 64'(resp), 64'h09);
            check("t5_req_ready_stall", 64'(reqReady), 64'h0);
        end
        respReady = 1'b1;
        acReady   = 4'h0;
        tick();
        check("t5_resp_valid_hs", 64'(respValid), 64'h0);
        check("t5_req_ready_hs", 64'(reqReady), 64'h1);
        check("t5_no_early_ac", 64'(acValid), 64'h0);
        tick();
        reqValid = 1'b0;
        check("t5_new_ac_valid", 64'(acValid), 64'h6);
        check("t5_new_ac_addr", acAddr, 64'h0000_0000_0000_ABC0);

        // Asynchronous reset in the middle of a broadcast.
        tick();
        check("t6_ac_valid_pre", 64'(acValid), 64'h6);
        rstN = 1'b0;
        #1;
        check("t6_rst_ac_valid", 64'(acValid), 64'h0);
        check("t6_rst_cr_ready", 64'(crReady), 64'h0);
        check("t6_rst_resp_valid", 64'(respValid), 64'h0);
        check("t6_rst_resp", 64'(resp), 64'h0);
        check("t6_rst_data", 64'({respDataVld, respDataIdx}), 64'h0);
        check("t6_rst_ac_addr", acAddr, 64'h0);
        tick();
        rstN = 1'b1;
        tick();
        check("t6_idle_ready", 64'(reqReady), 64'h1);
        portEn   = 4'b0001;
        reqInit  = 2'd0;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        check("t6_accept_resp", 64'(respValid), 64'h1);
        tick();
        check("t6_back_idle", 64'(reqReady), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
